clk_div_duty: RTL and testbench
===============================

# clk_div_duty

Synthesizable programmable clock-divider / duty-cycle generator. It derives a divided output waveform with programmable period and high time from the single system clock, and emits edge strobes alongside it. It is the RTL stage that produces the 1 MHz / 2 MHz / 30 %-duty style waveforms the benches model behaviourally, and downstream blocks consume its edge strobes as clock enables. Period and duty changes are double-buffered and take effect only at period boundaries, so the output never glitches.

## Interface
- `WIDTH`, 8: width of the period and high-time fields.
- `clock`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request (level).
- `load`  in  1  one-cycle strobe; captures `div_in` and `high_in`.
- `div_in`  in  WIDTH  period in `clock` cycles.
- `high_in`  in  WIDTH  high time in `clock` cycles.
- `clk_out`  out  1  divided waveform, registered.
- `rise_pulse`  out  1  one-cycle strobe, same cycle `clk_out` goes 0→1.
- `fall_pulse`  out  1  one-cycle strobe, same cycle `clk_out` goes 1→0.
- `updated`  out  1  one-cycle strobe when shadow values become active.
- `busy`  out  1  state ≠ IDLE.
- `period_cnt`  out  16  completed-period count (see Configuration).

## Operation
- Registers:
  - active `div_a` / `high_a`
  - shadow `div_s` / `high_s`
  - `pending` flag
  - counter `cnt`
  - FSM: IDLE, RUN, DRAIN
- Effective period `P = max(div_a, 2)`. Effective high time `H = min(high_a, P)`. `clk_out` is high while `cnt < H`. `H = 0` gives constant low; `H = P` gives constant high, with no edge strobes.
- `load` in IDLE: writes `div_a`/`high_a` and the shadow registers directly. `updated` pulses on the next cycle.
- `load` in RUN or DRAIN: writes the shadow registers and sets `pending`. A later `load` before the boundary overwrites the shadow registers (last write wins).
- At a period wrap (`cnt == P-1`) with `pending` set: shadow values are copied to active, `pending` clears, and `updated` pulses. The new `P`/`H` govern the cycle with `cnt = 0`.
- A `load` in the same cycle as a wrap is not applied at that wrap; it waits for the next one.
- IDLE → RUN when `enable = 1`. `cnt` is 0 and `clk_out = (H > 0)`.
- RUN → DRAIN when `enable = 0`. Counting continues through the current period.
- DRAIN → RUN when `enable = 1`. There is no interruption and `cnt` is unchanged.
- DRAIN → IDLE at wrap. `clk_out` goes to 0 (with `fall_pulse` if it was 1) and `cnt` goes to 0.
- The output period is exactly `P` cycles and the high time exactly `H` cycles, for every period including the first and last.

## Timing
- Reset values:
  - `clk_out`, `rise_pulse`, `fall_pulse`, `updated`, `busy`: 0
  - `period_cnt`: 0
  - `cnt`: 0
  - FSM: IDLE
  - `div_a = div_s = 2`, `high_a = high_s = 1`
  - `pending`: 0
- Start latency: `enable` sampled high at edge k makes `clk_out` and `rise_pulse` high after edge k (1 cycle).
- Each cycle in RUN/DRAIN: `cnt` becomes `(cnt == P-1) ? 0 : cnt+1`, and `clk_out` becomes `(next cnt < H)`. Strobes are derived from the previous versus the next value of `clk_out`.
- `updated` is asserted in the same cycle that the new values first drive `clk_out`.
- Reset asserted mid-period: all outputs clear immediately (asynchronously) with no strobes. Operation restarts from IDLE after release.
- `enable` toggling within a single period has no visible effect on `clk_out`.

## Configuration
- `CLKDIV_CYCLE_CNT_EN`:
  - Defined: `period_cnt` increments by 1 at every wrap in RUN/DRAIN, wraps at 16 bits (0xFFFF → 0), and is cleared only by `reset`.
  - Undefined: `period_cnt` is tied to 0 and no counter logic is synthesized.

## Test plan
- Reset, then `load` `div=2`, `high=1`, then `enable`: `clk_out` is high 1 cycle / low 1 cycle, and `rise_pulse` occurs every 2 cycles, starting 1 cycle after `enable`.
- `div=10`, `high=3`: 3 high / 7 low repeating (30 % duty). Exactly one `rise_pulse` and one `fall_pulse` per 10 cycles.
- In RUN with `div=4`, `high=2`, `load` `div=8`, `high=6`: the current period completes as 2/2, then `updated` pulses and 6/2 periods follow. A load coincident with a wrap applies one period later.
- Drop `enable` at `cnt = 1` with `div=6`: the period finishes, then `clk_out` stays 0 and `busy` is 0. Re-raising `enable` during DRAIN yields continuous output with no gap.
- `high=0` gives `clk_out` constant 0 with no strobes. `high=div=5` gives constant 1 after start. `div=0` behaves as `P=2`.
- With `CLKDIV_CYCLE_CNT_EN` defined, 20 periods give `period_cnt = 20`. An asynchronous reset asserted mid-run clears all outputs within the same cycle.

Source files
------------

// File: rtl/clk_div_duty.sv
// rtl/clk_div_duty.sv - programmable clock divider / duty-cycle generator with edge strobes
//
// Purpose: derives a divided waveform (period P = max(div,2), high time
// H = min(high,P)) from the system clock. Period/high changes made while
// running are held in shadow registers and applied only at a period wrap,
// so clk_out never glitches.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   enable              run request (level)
//   load                one-cycle strobe capturing div_in / high_in
//   div_in, high_in     period and high time in clock cycles
//   clk_out             divided waveform (registered)
//   rise_pulse          strobe in the cycle clk_out goes 0->1
//   fall_pulse          strobe in the cycle clk_out goes 1->0
//   updated             strobe in the cycle new settings first drive clk_out
//   busy                FSM not idle
//   period_cnt          completed-period count
//
// Optional feature: define CLKDIV_CYCLE_CNT_EN to build the 16-bit
// completed-period counter; otherwise period_cnt is tied to zero.

module clk_div_duty #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             updated,
    output logic             busy,
    output logic [15:0]      period_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] div_a, div_a_n, high_a, high_a_n;
    logic [WIDTH-1:0] div_s, div_s_n, high_s, high_s_n;
    logic             pending, pending_n;
    logic             clk_n, rise_n, fall_n, upd_n;
    logic [WIDTH-1:0] p_cur, h_cur;
    logic             wrap;

    function automatic logic [WIDTH-1:0] eff_p(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    function automatic logic [WIDTH-1:0] eff_h(input logic [WIDTH-1:0] h,
                                               input logic [WIDTH-1:0] p);
        return (h > p) ? p : h;
    endfunction

    assign p_cur = eff_p(div_a);
    assign h_cur = eff_h(high_a, p_cur);
    assign wrap  = (cnt == p_cur - WIDTH'(1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_a_n   = div_a;
        high_a_n  = high_a;
        div_s_n   = div_s;
        high_s_n  = high_s;
        pending_n = pending;
        clk_n     = clk_out;
        upd_n     = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                clk_n = 1'b0;
                if (load) begin
                    div_a_n   = div_in;
                    high_a_n  = high_in;
                    div_s_n   = div_in;
                    high_s_n  = high_in;
                    pending_n = 1'b0;
                    upd_n     = 1'b1;
                end
                // Start uses the values that will be active after this edge,
                // so a load coincident with enable governs the first period.
                if (enable) begin
                    state_n = RUN;
                    clk_n   = (eff_h(high_a_n, eff_p(div_a_n)) != '0);
                end
            end

            RUN, DRAIN: begin
                if (state == RUN && !enable)
                    state_n = DRAIN;
                else if (state == DRAIN && enable)
                    state_n = RUN;

                if (wrap) begin
                    cnt_n = '0;
                    // Copies the shadow as it stood before this edge; a load
                    // on this same edge refills the shadow for the next wrap.
                    if (pending) begin
                        div_a_n   = div_s;
                        high_a_n  = high_s;
                        pending_n = 1'b0;
                        upd_n     = 1'b1;
                    end
                    if (state == DRAIN && !enable) begin
                        state_n = IDLE;
                        clk_n   = 1'b0;
                    end else begin
                        clk_n = (eff_h(high_a_n, eff_p(div_a_n)) != '0);
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                    clk_n = ((cnt + WIDTH'(1)) < h_cur);
                end

                if (load) begin
                    div_s_n   = div_in;
                    high_s_n  = high_in;
                    pending_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                clk_n   = 1'b0;
            end
        endcase

        rise_n = clk_n & ~clk_out;
        fall_n = ~clk_n & clk_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            div_a      <= WIDTH'(2);
            high_a     <= WIDTH'(1);
            div_s      <= WIDTH'(2);
            high_s     <= WIDTH'(1);
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            updated    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            div_a      <= div_a_n;
            high_a     <= high_a_n;
            div_s      <= div_s_n;
            high_s     <= high_s_n;
            pending    <= pending_n;
            clk_out    <= clk_n;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
            updated    <= upd_n;
        end
    end

    assign busy = (state != IDLE);

`ifdef CLKDIV_CYCLE_CNT_EN
    logic        period_tick;
    logic [15:0] period_q;

    assign period_tick = (state != IDLE) && wrap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            period_q <= 16'd0;
        else if (period_tick)
            period_q <= period_q + 16'd1;
    end

    assign period_cnt = period_q;
`else
    assign period_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_clk_div_duty.sv
// tb/tb_clk_div_duty.sv - directed self-checking bench for clk_div_duty

module tb_clk_div_duty;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  div_in = 8'd0;
    logic [7:0]  high_in = 8'd0;
    logic        clk_out, rise_pulse, fall_pulse, updated, busy;
    logic [15:0] period_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int mcnt, mprev, rises, falls, exp_pc;

    clk_div_duty #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .div_in     (div_in),
        .high_in    (high_in),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .updated    (updated),
        .busy       (busy),
        .period_cnt (period_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected waveform: cnt steps mod p, clk_out = cnt < h, strobes from edges.
    task automatic run(input int p, input int h, input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            tick();
            mcnt = (mcnt == p - 1) ? 0 : mcnt + 1;
            e = (mcnt < h) ? 1 : 0;
            check("clk_out", clk_out, e);
            check("rise", rise_pulse, (e == 1 && mprev == 0) ? 1 : 0);
            check("fall", fall_pulse, (e == 0 && mprev == 1) ? 1 : 0);
            check("updated_idle", updated, 0);
            if (rise_pulse) rises++;
            if (fall_pulse) falls++;
            mprev = e;
        end
    endtask

    task automatic idle_load(input int d, input int h);
        load = 1'b1; div_in = 8'(d); high_in = 8'(h);
        tick();
        load = 1'b0;
        check("idle_load_updated", updated, 1);
        check("idle_load_busy", busy, 0);
    endtask

    task automatic start(input int exp_clk);
        enable = 1'b1;
        tick();
        check("start_busy", busy, 1);
        check("start_clk", clk_out, exp_clk);
        check("start_rise", rise_pulse, exp_clk);
        mcnt = 0;
        mprev = exp_clk;
    endtask

    task automatic drain_to_idle();
        enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!busy) break;
        end
        check("drain_busy", busy, 0);
        check("drain_clk", clk_out, 0);
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_clk", clk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_updated", updated, 0);
        check("rst_rise", rise_pulse, 0);
        check("rst_pc", period_cnt, 0);
        reset = 1'b0;
        tick();
        check("idle_clk", clk_out, 0);

        // div=2 high=1: 1/1 waveform, first rise one cycle after enable
        idle_load(2, 1);
        start(1);
        run(2, 1, 8);
        drain_to_idle();

        // div=10 high=3: 30 % duty, one rise and one fall per 10 cycles
        idle_load(10, 3);
        start(1);
        rises = 0; falls = 0;
        run(10, 3, 20);
        check("rises_20", rises, 2);
        check("falls_20", falls, 2);
        drain_to_idle();

        // Double-buffered change in RUN: 4/2 -> 8/6 at boundary
        idle_load(4, 2);
        start(1);
        run(4, 2, 1);
        load = 1'b1; div_in = 8'd8; high_in = 8'd6;
        run(4, 2, 1);
        load = 1'b0;
        run(4, 2, 1);
        tick();
        check("upd_pulse", updated, 1);
        check("upd_clk", clk_out, 1);
        check("upd_rise", rise_pulse, 1);
        mcnt = 0; mprev = 1;
        run(8, 6, 7);
        // Load coincident with a wrap is deferred one period
        load = 1'b1; div_in = 8'd3; high_in = 8'd1;
        run(8, 6, 1);
        load = 1'b0;
        run(8, 6, 7);
        tick();
        check("late_upd_pulse", updated, 1);
        check("late_upd_clk", clk_out, 1);
        mcnt = 0; mprev = 1;
        run(3, 1, 6);
        drain_to_idle();

        // Drop enable at cnt=1 with div=6: period completes then idle
        idle_load(6, 3);
        start(1);
        run(6, 3, 1);
        enable = 1'b0;
        run(6, 3, 4);
        check("drain_still_busy", busy, 1);
        tick();
        check("stop_busy", busy, 0);
        check("stop_clk", clk_out, 0);
        check("stop_fall", fall_pulse, 0);
        tick();
        check("stop_clk2", clk_out, 0);
        check("stop_rise2", rise_pulse, 0);

        // Re-raise enable during DRAIN: no gap
        start(1);
        run(6, 3, 2);
        enable = 1'b0;
        run(6, 3, 1);
        enable = 1'b1;
        run(6, 3, 8);
        check("resume_busy", busy, 1);
        drain_to_idle();

        // high=0: constant low
        idle_load(5, 0);
        start(0);
        run(5, 0, 10);
        drain_to_idle();

        // high=div=5: constant high, no strobes after start
        idle_load(5, 5);
        start(1);
        run(5, 5, 10);
        drain_to_idle();

        // div=0 behaves as P=2
        idle_load(0, 1);
        start(1);
        run(2, 1, 6);
        drain_to_idle();

        // Period counter over 20 periods, then asynchronous reset mid-run
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_load(4, 1);
        start(1);
        run(4, 1, 80);
`ifdef CLKDIV_CYCLE_CNT_EN
        exp_pc = 20;
`else
        exp_pc = 0;
`endif
        check("period_cnt_20", period_cnt, exp_pc);
        check("pre_rst_clk", clk_out, 1);
        reset = 1'b1;
        #1;
        check("async_rst_clk", clk_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rise", rise_pulse, 0);
        check("async_rst_fall", fall_pulse, 0);
        check("async_rst_pc", period_cnt, 0);
        tick();
        reset = 1'b0;
        enable = 1'b0;
        tick();
        check("post_rst_clk", clk_out, 0);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
